// File: rtl/button_reader_pkg.sv
// Shared definitions for the button reader: event encoding and width helpers.
package button_reader_pkg;

    localparam logic EVT_PRESS   = 1'b1;
    localparam logic EVT_RELEASE = 1'b0;

    // Event word layout: {edge, channel}; the channel field starts at bit 0.
    localparam int unsigned EVT_CH_LSB = 0;

    function automatic int unsigned chan_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned evt_edge_pos(input int unsigned chw);
        return EVT_CH_LSB + chw;
    endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-FF synchroniser, tick-paced stable counter, debounced level
// and registered press/release pulses that coincide with the level flip.
module btn_debounce_chan #(
    parameter int unsigned STABLE_TICKS = 4,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic hwclk,
    input  logic rst_n,
    input  logic tick,
    input  logic pin,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          pressed;

    assign pressed = sync_q[1] ^ ACTIVE_LOW;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (tick) begin
            if (pressed == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(STABLE_TICKS - 1)) begin
                level_d = pressed;
                cnt_d   = '0;
                press_d = pressed;
                rel_d   = !pressed;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            // Load the idle pin level so reset never looks like a press.
            sync_q  <= {2{ACTIVE_LOW}};
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pin};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;

endmodule

// File: rtl/button_reader.sv
// Debounced push-button reader with press/release pulses and a small event FIFO
// drained over a valid/ready handshake.
module button_reader
    import button_reader_pkg::*;
#(
    parameter int unsigned N_BTN         = 4,
    parameter int unsigned TICK_DIV_BITS = 16,
    parameter int unsigned STABLE_TICKS  = 4,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter bit          ACTIVE_LOW    = 1'b1,
    localparam int unsigned CHW          = chan_width(N_BTN)
) (
    input  logic             hwclk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CHW:0]     evt_data,
    output logic             evt_overflow
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned PW       = AW + 1;
    localparam int unsigned EDGE_POS = evt_edge_pos(CHW);

    logic [TICK_DIV_BITS-1:0] presc_q;
    logic                     tick;
    logic [N_BTN-1:0]         pend_q, pend_d;
    logic [N_BTN-1:0]         pedge_q, pedge_d;
    logic                     ovf_q, ovf_d;
    logic                     push, pop, full;
    logic [CHW:0]             push_data;
    logic [CHW:0]             mem_q [FIFO_DEPTH];
    logic [PW-1:0]            wr_q, rd_q;

    assign tick = &presc_q;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_debounce_chan #(
            .STABLE_TICKS (STABLE_TICKS),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_chan (
            .hwclk         (hwclk),
            .rst_n         (rst_n),
            .tick          (tick),
            .pin           (btn_in[g]),
            .level         (btn_level[g]),
            .press_pulse   (btn_press[g]),
            .release_pulse (btn_release[g])
        );
    end

    assign evt_valid    = (wr_q != rd_q);
    assign full         = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop          = evt_valid && evt_ready;
    assign evt_data     = evt_valid ? mem_q[rd_q[AW-1:0]] : '0;
    assign evt_overflow = ovf_q;

    always_comb begin
        pend_d    = pend_q;
        pedge_d   = pedge_q;
        ovf_d     = ovf_q;
        push      = 1'b0;
        push_data = '0;
        // Lowest-index pending channel wins the single push slot.
        if (!full || pop) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                if (pend_q[i] && !push) begin
                    push                         = 1'b1;
                    push_data[EVT_CH_LSB +: CHW] = CHW'(i);
                    push_data[EDGE_POS]          = pedge_q[i];
                    pend_d[i]                    = 1'b0;
                end
            end
        end
        // A flip on a channel that still holds an unqueued event is dropped.
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (btn_press[i] || btn_release[i]) begin
                if (pend_d[i]) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d[i]  = 1'b1;
                    pedge_d[i] = btn_press[i] ? EVT_PRESS : EVT_RELEASE;
                end
            end
        end
    end

    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            presc_q <= '0;
            pend_q  <= '0;
            pedge_q <= '0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            presc_q <= presc_q + TICK_DIV_BITS'(1);
            pend_q  <= pend_d;
            pedge_q <= pedge_d;
            ovf_q   <= ovf_d;
            if (push) wr_q <= wr_q + PW'(1);
            if (pop)  rd_q <= rd_q + PW'(1);
        end
    end

    always_ff @(posedge hwclk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= push_data;
    end

endmodule
